// File: rtl/rs232_tx_arbiter.sv
// Round-robin, message-locked arbiter that shares one push/full RS-232
// transmitter between N byte-stream sources and hides the transmitter's full lag.
module rs232_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic [N-1:0]   ireq,
  input  logic [8*N-1:0] idata,
  input  logic [N-1:0]   ipush,
  input  logic [N-1:0]   ilast,
  output logic [N-1:0]   ifull,
  output logic [N-1:0]   ogrant,
  output logic [N-1:0]   overrun,
  output logic [7:0]     odata,
  output logic           opush,
  input  logic           ofull
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [1:0]    holdoff_q, holdoff_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [N-1:0]  ogrant_q, ogrant_d;
  logic [N-1:0]  overrun_q, overrun_d;
  logic [7:0]    odata_q, odata_d;
  logic          opush_q, opush_d;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          accept;
  logic          release_lock;

  // First requester strictly after last_q in circular order; the loop runs
  // backwards so the nearest candidate is the one left standing.
  always_comb begin
    int idx;
    idx        = 0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_q) + k) % N;
      if (ireq[idx]) begin
        pick_idx   = IW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ifull[i] = !(state_q == LOCKED && grant_q == IW'(i) &&
                   holdoff_q == 2'd0 && !ofull);
    end
  end

  assign accept = ipush[grant_q] && !ifull[grant_q];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the branches below leaves it unassigned and infers a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    idle_cnt_d   = idle_cnt_q;
    ogrant_d     = ogrant_q;
    odata_d      = odata_q;
    opush_d      = 1'b0;
    holdoff_d    = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;
    overrun_d    = overrun_q | (ipush & ifull);
    release_lock = 1'b0;

    if (state_q == IDLE) begin
      if (pick_valid) begin
        grant_d    = pick_idx;
        ogrant_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
        idle_cnt_d = '0;
        state_d    = LOCKED;
      end
    end else begin
      if (accept) begin
        odata_d   = idata[{grant_q, 3'b000} +: 8];
        opush_d   = 1'b1;
        holdoff_d = 2'd2;
        if (ilast[grant_q]) release_lock = 1'b1;
      end
      if (ireq[grant_q]) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
        release_lock = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + CW'(1);
      end
      if (release_lock) begin
        state_d  = IDLE;
        last_d   = grant_q;
        ogrant_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(N - 1);
      holdoff_q  <= 2'd0;
      idle_cnt_q <= '0;
      ogrant_q   <= '0;
      overrun_q  <= '0;
      odata_q    <= 8'h00;
      opush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      holdoff_q  <= holdoff_d;
      idle_cnt_q <= idle_cnt_d;
      ogrant_q   <= ogrant_d;
      overrun_q  <= overrun_d;
      odata_q    <= odata_d;
      opush_q    <= opush_d;
    end
  end

  assign ogrant  = ogrant_q;
  assign overrun = overrun_q;
  assign odata   = odata_q;
  assign opush   = opush_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: single byte, fairness, holdoff,
// timeout, overrun and asynchronous reset in the middle of a message.
module tb_rs232_tx_arbiter;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           resetn;
  logic [N-1:0]   ireq;
  logic [8*N-1:0] idata;
  logic [N-1:0]   ipush;
  logic [N-1:0]   ilast;
  logic [N-1:0]   ifull;
  logic [N-1:0]   ogrant;
  logic [N-1:0]   overrun;
  logic [7:0]     odata;
  logic           opush;
  logic           ofull;

  int passes = 0;
  int total  = 0;

  rs232_tx_arbiter #(.N(N), .TIMEOUT(4)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .ireq    (ireq),
    .idata   (idata),
    .ipush   (ipush),
    .ilast   (ilast),
    .ifull   (ifull),
    .ogrant  (ogrant),
    .overrun (overrun),
    .odata   (odata),
    .opush   (opush),
    .ofull   (ofull)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ireq   = '0;
    ipush  = '0;
    ilast  = '0;
    idata  = '0;
    ofull  = 1'b0;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  // Waits (bounded) for ifull[s] low, pushes one byte and checks it reaches
  // the transmitter on the next cycle.
  task automatic send_byte(input int s, input logic [7:0] d, input logic l, input string tag);
    int n;
    n = 0;
    while (ifull[s] && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, 32'(n < 20), 32'd1);
    idata[8*s +: 8] = d;
    ipush[s]        = 1'b1;
    ilast[s]        = l;
    tick();
    ipush = '0;
    ilast = '0;
    check({tag, "_opush"}, 32'(opush), 32'd1);
    check({tag, "_odata"}, 32'(odata), 32'(d));
  endtask

  initial begin
    int op_exp [7];
    int if_exp [7];
    op_exp = '{1, 0, 0, 1, 0, 0, 1};
    if_exp = '{1, 1, 0, 1, 1, 0, 1};

    resetn = 1'b0;
    ireq   = '0;
    ipush  = '0;
    ilast  = '0;
    idata  = '0;
    ofull  = 1'b0;
    #12;
    check("rst_ogrant",  32'(ogrant),  32'h0);
    check("rst_opush",   32'(opush),   32'h0);
    check("rst_odata",   32'(odata),   32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_ifull",   32'(ifull),   32'hF);
    resetn = 1'b1;

    // Single source, single byte
    ireq = 4'b0001;
    tick();
    check("single_grant", 32'(ogrant), 32'b0001);
    check("single_ifull", 32'(ifull),  32'b1110);
    send_byte(0, 8'hA5, 1'b1, "single");
    check("single_release", 32'(ogrant), 32'h0);
    ireq = '0;
    tick();
    check("single_opush_pulse", 32'(opush), 32'h0);

    // Fairness: all sources request, each sends two bytes
    do_reset();
    ireq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int s;
      s = k % N;
      tick();
      check($sformatf("fair_grant%0d", k), 32'(ogrant), 32'(1 << s));
      send_byte(s, 8'(s * 16 + 10), 1'b0, $sformatf("fair%0d_b0", k));
      check($sformatf("fair_hold%0d", k), 32'(ogrant), 32'(1 << s));
      send_byte(s, 8'(s * 16 + 11), 1'b1, $sformatf("fair%0d_b1", k));
      check($sformatf("fair_rel%0d", k), 32'(ogrant), 32'h0);
    end

    // Holdoff: source 1 pushes every cycle, ofull low
    do_reset();
    ireq = 4'b0010;
    tick();
    check("hold_grant", 32'(ogrant), 32'b0010);
    idata[15:8] = 8'h5C;
    ipush       = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("hold_opush%0d", k), 32'(opush), 32'(op_exp[k]));
      check($sformatf("hold_ifull%0d", k), 32'(ifull[1]), 32'(if_exp[k]));
      if (op_exp[k] == 1) check($sformatf("hold_odata%0d", k), 32'(odata), 32'h5C);
    end
    ipush = '0;
    ofull = 1'b1;
    tick();
    tick();
    tick();
    check("ofull_block_ifull", 32'(ifull), 32'hF);
    check("ofull_block_opush", 32'(opush), 32'h0);
    check("ofull_keeps_lock",  32'(ogrant), 32'b0010);
    ofull = 1'b0;
    #1;
    check("ofull_release_ifull", 32'(ifull), 32'b1101);

    // Timeout with TIMEOUT=4: source 2 drops ireq, source 3 waits
    do_reset();
    ireq = 4'b0100;
    tick();
    check("to_grant", 32'(ogrant), 32'b0100);
    send_byte(2, 8'h22, 1'b0, "to_byte");
    ireq = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("to_locked%0d", k), 32'(ogrant), 32'b0100);
    end
    tick();
    check("to_release", 32'(ogrant), 32'h0);
    tick();
    check("to_next", 32'(ogrant), 32'b1000);

    // Overrun: source 0 pushes while source 1 holds the lock
    do_reset();
    ireq = 4'b0010;
    tick();
    check("ovr_grant", 32'(ogrant), 32'b0010);
    send_byte(1, 8'hB1, 1'b0, "ovr_b0");
    idata[7:0] = 8'h11;
    ipush      = 4'b0001;
    tick();
    ipush = '0;
    check("ovr_flag",  32'(overrun), 32'b0001);
    check("ovr_opush", 32'(opush),   32'h0);
    send_byte(1, 8'hB2, 1'b1, "ovr_b1");
    check("ovr_sticky", 32'(overrun), 32'b0001);

    // Reset in the middle of a 3-byte message from source 2
    ireq = 4'b0100;
    tick();
    check("mid_grant", 32'(ogrant), 32'b0100);
    send_byte(2, 8'hC1, 1'b0, "mid_b0");
    send_byte(2, 8'hC2, 1'b0, "mid_b1");
    resetn = 1'b0;
    #1;
    check("mid_opush",   32'(opush),   32'h0);
    check("mid_ogrant",  32'(ogrant),  32'h0);
    check("mid_overrun", 32'(overrun), 32'h0);
    check("mid_odata",   32'(odata),   32'h0);
    ireq = 4'b0101;
    #1;
    resetn = 1'b1;
    tick();
    check("mid_first_grant", 32'(ogrant), 32'b0001);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Shares one `push_to_rs232` transmitter between N byte-stream sources using the push/full convention. Arbitration is round-robin and message-locked: a granted source keeps the transmitter until it pushes a byte flagged `ilast` or stops requesting for TIMEOUT cycles, so messages are never interleaved on the serial line. The block sits between the per-source producers and the transmitter's `data`/`push`/`full` port. It compensates for the transmitter's two-cycle `full` lag.

## Interface
- N, 4: number of sources, 2..16.
- TIMEOUT, 64: consecutive cycles with the holder's `ireq` low before its lock is released, at least 1.
- clock  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- ireq  in  N  per-source level request; bit i belongs to source i.
- idata  in  8*N  per-source byte; source i uses bits [8i+7:8i].
- ipush  in  N  per-source push; valid only while the matching `ifull` bit is low.
- ilast  in  N  qualifies `ipush`: the byte is the last of the message.
- ifull  out  N  per-source full, combinational from registers and `ofull`.
- ogrant  out  N  one-hot registered grant; zero when no source is granted.
- overrun  out  N  sticky flag: the source pushed while its `ifull` was high.
- odata  out  8  byte to the transmitter, registered.
- opush  out  1  push to the transmitter, registered, one-cycle pulse.
- ofull  in  1  transmitter `full`.

## Operation
- States: IDLE and LOCKED. Registers: `grant` index, `last` index, `holdoff` (2 bits), `idle_cnt` (width $clog2(TIMEOUT+1)).
- Reset values: state IDLE, `ogrant` 0, `last` N-1 (so source 0 wins first), `holdoff` 0, `idle_cnt` 0, `odata` 8'h00, `opush` 0, `overrun` 0.
- IDLE: if any `ireq` bit is set, pick the first set bit searching from `last`+1 upward, modulo N.
  - Load `grant` with that index, set `ogrant`, clear `idle_cnt`, go to LOCKED.
  - `holdoff` keeps counting down in IDLE.
- Accept condition is `ifull[i]` = !(LOCKED && grant==i && holdoff==0 && !ofull). Every non-granted bit is 1.
- Accepted byte (`ipush[grant]` && !`ifull[grant]`):
  - Next cycle: `odata` = that source's byte and `opush` = 1.
  - `holdoff` is loaded with 2.
  - If `ilast[grant]`: go to IDLE, `last` = `grant`, `ogrant` = 0.
- `holdoff` decrements each cycle while nonzero. It covers the cycle `opush` is high plus the cycle before the transmitter's registered `full` rises.
- Timeout: in LOCKED, `idle_cnt` increments while `ireq[grant]` is low and clears while it is high.
  - At `idle_cnt` == TIMEOUT-1 with `ireq[grant]` still low: release as for `ilast`. `last` = `grant`.
  - An accepted byte in that same cycle is still forwarded.
- `ipush[i]` while `ifull[i]`==1: the byte is dropped and `overrun[i]` is set until reset. This includes pushes from non-granted sources.
- `ipush` bits without a matching accept do not affect state.

## Timing
- Request to grant: `ireq` sampled high in cycle t gives `ogrant` in t+1. The earliest accept is t+1, when `ifull` first goes low.
- Accept to transmitter: accept in cycle t gives `opush` in t+1. `ifull` is held high through t+1 and t+2 by `holdoff`. From t+3 it follows `ofull`.
- Back-to-back messages: a release in cycle t allows a new grant in t+1, with the next source in rotation. A released source re-requesting competes normally.
- `ofull` high blocks every accept without affecting lock or timeout.
- Async reset mid-message:
  - All outputs return to reset values immediately and the partial message is abandoned.
  - `opush` drops in the same instant, so no byte reaches the transmitter after reset.

## Test plan
- Single source, single byte: `ireq[0]`=1, push 8'hA5 with `ilast`.
  - Required: `ogrant`=4'b0001 one cycle after `ireq`, `opush` with `odata`=8'hA5 one cycle after the accept, then `ogrant`=0.
- Fairness: `ireq`=4'b1111 held, each source sends a 2-byte message.
  - Required: grant order 0,1,2,3,0; `odata` never interleaves bytes from two sources.
- Holdoff: `ofull` tied low, source 1 pushes continuously.
  - Required: consecutive `opush` pulses are exactly 3 cycles apart; `ifull[1]` is high for 2 cycles after each accept.
- Timeout (TIMEOUT=4): source 2 locks, sends one byte without `ilast`, drops `ireq`.
  - Required: `ogrant` clears after 4 low cycles; source 3 is granted next.
- Overrun: source 0 pushes 8'h11 while source 1 holds the lock.
  - Required: `overrun`=4'b0001, no `opush`, source 1's message unaffected.
- Reset mid-message: assert `resetn` low during a 3-byte message.
  - Required: `opush`=0, `ogrant`=0, `overrun`=0 at once; after release, source 0 is granted first.
